seq_controller_ws: RTL

SEQ_CONTROLLER_WS -- requirements
Module: seq_controller_ws

---
 rtl/seq_controller_ws.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_controller_ws.sv
// Eight-phase accumulator-CPU sequencer: fetch, decode, operand, ALU, store.
// Ports: clk, rst, opcode, zero, mem_ready, resume -> controls, phase, stall, instr_count.
module seq_controller_ws #(
  parameter int OPW  = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  input  logic            resume,
  output logic            memrd,
  output logic            memwr,
  output logic            loadir,
  output logic            incpc,
  output logic            loadac,
  output logic            loadpc,
  output logic            halt,
  output logic [2:0]      phase,
  output logic            stall,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t          ph;
  logic            halted;
  logic [CNTW-1:0] cnt;

  logic op_hlt, op_skz, op_add, op_and;
  logic op_xor, op_lda, op_sto, op_jmp;
  logic aluop;

  // Full-width compare: wider opcodes outside 0..7 decode to nothing.
  assign op_hlt = (opcode == OPW'(0));
  assign op_skz = (opcode == OPW'(1));
  assign op_add = (opcode == OPW'(2));
  assign op_and = (opcode == OPW'(3));
  assign op_xor = (opcode == OPW'(4));
  assign op_lda = (opcode == OPW'(5));
  assign op_sto = (opcode == OPW'(6));
  assign op_jmp = (opcode == OPW'(7));
  assign aluop  = op_add | op_and | op_xor | op_lda;

  always_comb begin
    memrd  = 1'b0;
    memwr  = 1'b0;
    loadir = 1'b0;
    incpc  = 1'b0;
    loadac = 1'b0;
    loadpc = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      // Resume releases the halt and steps the PC past the HLT.
      halt  = !resume;
      incpc = resume;
    end else begin
      unique case (ph)
        INST_ADDR: ;
        INST_FETCH: memrd = 1'b1;
        INST_LOAD, IDLE: begin
          memrd  = 1'b1;
          loadir = 1'b1;
        end
        OP_ADDR: begin
          incpc = !op_hlt;
          halt  = op_hlt;
        end
        OP_FETCH: memrd = aluop;
        ALU_OP: begin
          memrd  = aluop;
          loadac = aluop;
          incpc  = op_skz & zero;
          loadpc = op_jmp;
        end
        STORE: begin
          memrd  = aluop;
          loadac = aluop;
          loadpc = op_jmp;
          memwr  = op_sto;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!halted && !mem_ready) begin
      stall = (ph == INST_FETCH)
            | ((ph == OP_FETCH) & memrd)
            | ((ph == STORE) & memwr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph     <= INST_ADDR;
      halted <= 1'b0;
      cnt    <= '0;
    end else if (halted) begin
      if (resume) begin
        halted <= 1'b0;
        ph     <= OP_FETCH;
      end
    end else if (!stall) begin
      if (ph == OP_ADDR && op_hlt) begin
        halted <= 1'b1;
      end else begin
        ph <= phase_t'(ph + 3'd1);
      end
      if (ph == STORE && cnt != {CNTW{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign phase       = ph;
  assign instr_count = cnt;

endmodule
